// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC/nPC register pair.
// Takes the resolved branch condition (CH_Out) and the branch/jump targets
// from EX. Produces the fetch address, the next-sequential address and the
// IF/ID flush pulse. A redirect that resolves while the pipe is stalled is
// captured and applied when the stall releases; the first captured redirect
// wins.
// Optional build macro: DELAY_SLOT_EN
//   defined   : a redirect keeps the delay-slot instruction (pc<=npc, npc<=target)
//               and if_id_flush is held low.
//   undefined : a redirect fetches the target at once (pc<=target,
//               npc<=target+4) and if_id_flush kills the wrong-path fetch.
module pc_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic              CH_Out,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              if_id_flush,
    output logic              redirect_pending,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(4);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] npc_reg, npc_next;
    logic [ADDR_W-1:0] pend_tgt_reg, pend_tgt_next;
    logic              flush_reg, flush_next;
    logic              addr_err_reg, addr_err_next;

    logic              take;
    logic [ADDR_W-1:0] tgt_raw;
    logic [ADDR_W-1:0] tgt_aligned;
    logic              apply;
    logic [ADDR_W-1:0] apply_tgt;

    // Redirect request this cycle; a jump beats a branch when both resolve.
    always_comb begin
        take        = jump_valid | (branch_valid & CH_Out);
        tgt_raw     = jump_valid ? jump_target : branch_target;
        tgt_aligned = {tgt_raw[ADDR_W-1:2], 2'b00};
    end

    // Next-state logic: sequential step, immediate redirect, capture while
    // stalled, or release of a captured redirect.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        npc_next      = npc_reg;
        pend_tgt_next = pend_tgt_reg;
        flush_next    = 1'b0;
        // Any misaligned taken target is recorded, even one that is ignored
        // because an earlier redirect is already pending.
        addr_err_next = addr_err_reg | (take & (tgt_raw[1:0] != 2'b00));
        apply         = 1'b0;
        apply_tgt     = '0;

        case (state_reg)
            RUN, HOLD: begin
                if (!stall) begin
                    state_next = RUN;
                    if (take) begin
                        apply     = 1'b1;
                        apply_tgt = tgt_aligned;
                    end else begin
                        pc_next  = npc_reg;
                        npc_next = npc_reg + INC;
                    end
                end else if (take) begin
                    pend_tgt_next = tgt_aligned;
                    state_next    = PEND;
                end else begin
                    state_next = HOLD;
                end
            end
            PEND: begin
                // New takes are ignored here: the captured redirect wins.
                if (!stall) begin
                    apply      = 1'b1;
                    apply_tgt  = pend_tgt_reg;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (apply) begin
`ifdef DELAY_SLOT_EN
            pc_next  = npc_reg;
            npc_next = apply_tgt;
`else
            pc_next    = apply_tgt;
            npc_next   = apply_tgt + INC;
            flush_next = 1'b1;
`endif
        end
    end

    // State and datapath registers; reset drops any pending target and flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            npc_reg      <= RESET_PC + INC;
            pend_tgt_reg <= '0;
            flush_reg    <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            npc_reg      <= npc_next;
            pend_tgt_reg <= pend_tgt_next;
            flush_reg    <= flush_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        pc               = pc_reg;
        npc              = npc_reg;
        if_id_flush      = flush_reg;
        redirect_pending = (state_reg == PEND);
        addr_err         = addr_err_reg;
    end

endmodule
